// File: rtl/uart_boot_pkg.sv
// Shared definitions for the UART boot loader: FSM state and frame-phase
// enums, protocol byte values and UART register offsets.
// No ports; imported with `import uart_boot_pkg::*;`.
package uart_boot_pkg;

  typedef enum logic [2:0] {
    StPollRx,
    StReadRx,
    StProcess,
    StPollTx,
    StWriteTx,
    StDone
  } state_e;

  typedef enum logic [2:0] {
    PhMagic,
    PhLenLo,
    PhLenHi,
    PhData,
    PhCsum
  } phase_e;

  localparam logic [7:0] MagicByte = 8'hA5;
  localparam logic [7:0] AckByte   = 8'h06;
  localparam logic [7:0] NakByte   = 8'h15;

  // Byte offsets inside the UART register window
  localparam logic [31:0] RxOffset     = 32'h0;
  localparam logic [31:0] TxOffset     = 32'h4;
  localparam logic [31:0] StatusOffset = 32'h8;

  // STATUS register bit positions
  localparam int unsigned StatusRxValidBit = 0;
  localparam int unsigned StatusTxBusyBit  = 1;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Bus bundle of the UART boot loader.
//   mmio_*  : initiator side of the UART register window (addr, byte write
//             data, byte read data, one-cycle write/read strobes)
//   mem_*   : instruction-memory write port (byte address, word, write pulse)
// Modports: master = boot loader, slave = UART peripheral plus memory.
interface uart_boot_loader_if;

  logic [31:0] mmio_addr;
  logic [7:0]  mmio_data_out;
  logic [7:0]  mmio_data_in;
  logic        mmio_we;
  logic        mmio_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;

  modport master (
    output mmio_addr, mmio_data_out, mmio_we, mmio_re, mem_addr, mem_wdata, mem_we,
    input  mmio_data_in
  );

  modport slave (
    input  mmio_addr, mmio_data_out, mmio_we, mmio_re, mem_addr, mem_wdata, mem_we,
    output mmio_data_in
  );

endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader. Holds the CPU in reset, polls the UART register window for
// a framed image (A5, 16-bit LE word count, LE data words, optional checksum),
// writes the words into instruction memory and answers ACK (06) or NAK (15).
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : uart_boot_loader_if.master (MMIO initiator + memory write port)
//   o_cpu_rst    : high until a load has completed
//   o_done       : sticky, high after a successful load
//   o_error      : one-cycle pulse on a length or checksum error
// Build option: define UART_BOOT_CHECKSUM_EN to require a trailing XOR checksum
// byte over all data bytes.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [31:0] LOAD_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic                i_clk,
  input  logic                i_rst,
  uart_boot_loader_if.master  bus,
  output logic                o_cpu_rst,
  output logic                o_done,
  output logic                o_error
);

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] idx_q, idx_d;
  logic [15:0] len_q, len_d;
  logic [23:0] word_q, word_d;
  logic [7:0]  reply_q, reply_d;
  logic        to_tx_q, to_tx_d;

  logic [31:0] mmio_addr_q, mmio_addr_d;
  logic [7:0]  mmio_data_out_q, mmio_data_out_d;
  logic        mmio_we_q, mmio_we_d;
  logic        mmio_re_q, mmio_re_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

`ifdef UART_BOOT_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic [7:0]  rx_byte;
  logic [15:0] len_full;

  assign rx_byte  = bus.mmio_data_in;
  assign len_full = {rx_byte, len_q[7:0]};

  // Byte handling happens on the READ_RX -> PROCESS transition so that the
  // registered memory write and error pulse are visible during PROCESS.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bcnt_d      = bcnt_q;
    idx_d       = idx_q;
    len_d       = len_q;
    word_d      = word_q;
    reply_d     = reply_q;
    to_tx_d     = to_tx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = 32'h0;
    mem_wdata_d = 32'h0;
    error_d     = 1'b0;
`ifdef UART_BOOT_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    unique case (state_q)
      StPollRx: begin
        if (rx_byte[StatusRxValidBit]) state_d = StReadRx;
      end
      StReadRx: begin
        state_d = StProcess;
        to_tx_d = 1'b0;
        unique case (phase_q)
          PhMagic: begin
            if (rx_byte == MagicByte) phase_d = PhLenLo;
          end
          PhLenLo: begin
            len_d[7:0] = rx_byte;
            phase_d    = PhLenHi;
          end
          PhLenHi: begin
            len_d = len_full;
            if ({16'h0, len_full} > MAX_WORDS) begin
              error_d = 1'b1;
              reply_d = NakByte;
              to_tx_d = 1'b1;
              phase_d = PhMagic;
`ifdef UART_BOOT_CHECKSUM_EN
              csum_d  = 8'h0;
`endif
            end else if (len_full == 16'h0) begin
`ifdef UART_BOOT_CHECKSUM_EN
              phase_d = PhCsum;
`else
              reply_d = AckByte;
              to_tx_d = 1'b1;
`endif
            end else begin
              phase_d = PhData;
              idx_d   = 32'h0;
              bcnt_d  = 2'd0;
            end
          end
          PhData: begin
            bcnt_d = bcnt_q + 2'd1;
`ifdef UART_BOOT_CHECKSUM_EN
            csum_d = csum_q ^ rx_byte;
`endif
            unique case (bcnt_q)
              2'd0: word_d[7:0]   = rx_byte;
              2'd1: word_d[15:8]  = rx_byte;
              2'd2: word_d[23:16] = rx_byte;
              default: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = LOAD_ADDR + (idx_q << 2);
                mem_wdata_d = {rx_byte, word_q};
                idx_d       = idx_q + 32'd1;
                if (idx_q + 32'd1 == {16'h0, len_q}) begin
`ifdef UART_BOOT_CHECKSUM_EN
                  phase_d = PhCsum;
`else
                  reply_d = AckByte;
                  to_tx_d = 1'b1;
`endif
                end
              end
            endcase
          end
          PhCsum: begin
`ifdef UART_BOOT_CHECKSUM_EN
            to_tx_d = 1'b1;
            if (rx_byte == csum_q) begin
              reply_d = AckByte;
            end else begin
              error_d = 1'b1;
              reply_d = NakByte;
              phase_d = PhMagic;
              csum_d  = 8'h0;
            end
`else
            phase_d = PhMagic;
`endif
          end
          default: phase_d = PhMagic;
        endcase
      end
      StProcess: begin
        state_d = to_tx_q ? StPollTx : StPollRx;
      end
      StPollTx: begin
        if (!rx_byte[StatusTxBusyBit]) state_d = StWriteTx;
      end
      StWriteTx: begin
        state_d = (reply_q == AckByte) ? StDone : StPollRx;
      end
      StDone: begin
        state_d = StDone;
      end
      default: state_d = StPollRx;
    endcase

    // Bus outputs are a registered decode of the next state
    mmio_re_d       = 1'b0;
    mmio_we_d       = 1'b0;
    mmio_addr_d     = 32'h0;
    mmio_data_out_d = 8'h0;
    case (state_d)
      StPollRx, StPollTx: begin
        mmio_re_d   = 1'b1;
        mmio_addr_d = BASE_ADDR + StatusOffset;
      end
      StReadRx: begin
        mmio_re_d   = 1'b1;
        mmio_addr_d = BASE_ADDR + RxOffset;
      end
      StWriteTx: begin
        mmio_we_d       = 1'b1;
        mmio_addr_d     = BASE_ADDR + TxOffset;
        mmio_data_out_d = reply_d;
      end
      default: ;
    endcase

    done_d    = done_q | ((state_d == StWriteTx) && (reply_d == AckByte));
    cpu_rst_d = ~done_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= StPollRx;
      phase_q         <= PhMagic;
      bcnt_q          <= 2'd0;
      idx_q           <= 32'h0;
      len_q           <= 16'h0;
      word_q          <= 24'h0;
      reply_q         <= 8'h0;
      to_tx_q         <= 1'b0;
      mmio_addr_q     <= 32'h0;
      mmio_data_out_q <= 8'h0;
      mmio_we_q       <= 1'b0;
      mmio_re_q       <= 1'b0;
      mem_addr_q      <= 32'h0;
      mem_wdata_q     <= 32'h0;
      mem_we_q        <= 1'b0;
      cpu_rst_q       <= 1'b1;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
`ifdef UART_BOOT_CHECKSUM_EN
      csum_q          <= 8'h0;
`endif
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      bcnt_q          <= bcnt_d;
      idx_q           <= idx_d;
      len_q           <= len_d;
      word_q          <= word_d;
      reply_q         <= reply_d;
      to_tx_q         <= to_tx_d;
      mmio_addr_q     <= mmio_addr_d;
      mmio_data_out_q <= mmio_data_out_d;
      mmio_we_q       <= mmio_we_d;
      mmio_re_q       <= mmio_re_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_we_q        <= mem_we_d;
      cpu_rst_q       <= cpu_rst_d;
      done_q          <= done_d;
      error_q         <= error_d;
`ifdef UART_BOOT_CHECKSUM_EN
      csum_q          <= csum_d;
`endif
    end
  end

  assign bus.mmio_addr     = mmio_addr_q;
  assign bus.mmio_data_out = mmio_data_out_q;
  assign bus.mmio_we       = mmio_we_q;
  assign bus.mmio_re       = mmio_re_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_we        = mem_we_q;
  assign o_cpu_rst         = cpu_rst_q;
  assign o_done            = done_q;
  assign o_error           = error_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: a UART/memory model on the slave side, a table
// of directed frames, hand sequences for TX back-pressure and mid-load reset,
// and random frames checked against a frame-level parser model.
module tb_uart_boot_loader;
  import uart_boot_pkg::*;

  localparam logic [31:0] Base = 32'h1000_0000;
  localparam int unsigned MaxW = 4;
`ifdef UART_BOOT_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dut_cpu_rst, dut_done, dut_error;

  uart_boot_loader_if bus ();

  uart_boot_loader #(
    .BASE_ADDR(Base),
    .LOAD_ADDR(32'h0),
    .MAX_WORDS(MaxW)
  ) u_dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .bus      (bus),
    .o_cpu_rst(dut_cpu_rst),
    .o_done   (dut_done),
    .o_error  (dut_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  stim[$];
  logic [39:0] tx_log[$];
  logic [63:0] wr_log[$];
  logic [63:0] exp_wr[$];
  logic [7:0]  exp_tx[$];
  int          exp_err;
  bit          exp_done;
  int          err_cnt = 0;
  int          viol = 0;
  int          cyc = 0;
  int          last_ready = 0;
  bit          pop_pend = 1'b0;
  bit          tx_busy = 1'b0;
  bit          gate = 1'b0;
  logic [7:0]  rdata = 8'h0;

  assign bus.mmio_data_in = rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // UART + memory model, evaluated on the falling edge while DUT outputs are stable
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (pop_pend) begin
        if (rx_q.size() > 0) void'(rx_q.pop_front());
        pop_pend = 1'b0;
      end
      gate = ($urandom_range(0, 3) != 0);
      if (bus.mmio_we && bus.mmio_re) viol++;
      if (!bus.mmio_we && !bus.mmio_re && bus.mmio_addr != 32'h0) viol++;
      rdata = 8'h0;
      if (bus.mmio_re && bus.mmio_addr == Base + StatusOffset) begin
        rdata = {6'b0, tx_busy, gate && (rx_q.size() > 0)};
        if (rdata[0]) last_ready = cyc;
      end else if (bus.mmio_re && bus.mmio_addr == Base + RxOffset) begin
        rdata    = (rx_q.size() > 0) ? rx_q[0] : 8'h0;
        pop_pend = 1'b1;
      end
      if (bus.mmio_we) tx_log.push_back({bus.mmio_addr, bus.mmio_data_out});
      if (bus.mem_we) begin
        wr_log.push_back({bus.mem_addr, bus.mem_wdata});
        check("mem_we_latency", cyc - last_ready, 2);
      end
      if (dut_error) err_cnt++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_q.delete();
    pop_pend = 1'b0;
    tx_log.delete();
    wr_log.delete();
    err_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load_stim();
    foreach (stim[i]) rx_q.push_back(stim[i]);
  endtask

  task automatic wait_drained();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rx_q.size() == 0 && !pop_pend) begin
        ok = 1'b1;
        break;
      end
    end
    check("rx_drained", 32'(ok), 1);
  endtask

  task automatic wait_idle(input int ntx);
    bit ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (tx_log.size() >= ntx && rx_q.size() == 0 && !pop_pend) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (10) @(negedge clk);
    check("wait_complete", 32'(ok), 1);
  endtask

  task automatic compare_run(input string tag);
    check({tag, "_wr_count"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
      check({tag, "_wr_addr"}, wr_log[i][63:32], exp_wr[i][63:32]);
      check({tag, "_wr_data"}, wr_log[i][31:0], exp_wr[i][31:0]);
    end
    check({tag, "_tx_count"}, tx_log.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++) begin
      check({tag, "_tx_addr"}, tx_log[i][39:8], Base + 32'h4);
      check({tag, "_tx_data"}, 32'(tx_log[i][7:0]), 32'(exp_tx[i]));
    end
    check({tag, "_err_pulses"}, err_cnt, exp_err);
    check({tag, "_done"}, 32'(dut_done), 32'(exp_done));
    check({tag, "_cpu_rst"}, 32'(dut_cpu_rst), 32'(!exp_done));
  endtask

  // Frame-level parser: what a host would expect from the byte stream
  task automatic model();
    int pos = 0;
    int n;
    logic [7:0] acc;
    logic [31:0] w;
    exp_wr.delete();
    exp_tx.delete();
    exp_err = 0;
    exp_done = 1'b0;
    while (pos < stim.size() && !exp_done) begin
      pos++;
      if (stim[pos-1] != MagicByte) continue;
      if (pos + 2 > stim.size()) break;
      n = {stim[pos+1], stim[pos]};
      pos += 2;
      if (n > MaxW) begin
        exp_err++;
        exp_tx.push_back(NakByte);
        continue;
      end
      if (pos + 4 * n > stim.size()) break;
      acc = 8'h0;
      for (int k = 0; k < n; k++) begin
        w = {stim[pos+3], stim[pos+2], stim[pos+1], stim[pos]};
        acc = acc ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        exp_wr.push_back({32'(4 * k), w});
        pos += 4;
      end
      if (CsumEn) begin
        if (pos >= stim.size()) break;
        pos++;
        if (stim[pos-1] != acc) begin
          exp_err++;
          exp_tx.push_back(NakByte);
          continue;
        end
      end
      exp_tx.push_back(AckByte);
      exp_done = 1'b1;
    end
  endtask

  task automatic add_frame(input int n, input bit corrupt);
    logic [7:0] b;
    logic [7:0] acc = 8'h0;
    stim.push_back(MagicByte);
    stim.push_back(n[7:0]);
    stim.push_back(n[15:8]);
    if (n <= MaxW) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom_range(0, 255));
        acc ^= b;
        stim.push_back(b);
      end
      if (CsumEn) stim.push_back(corrupt ? ~acc : acc);
    end
  endtask

  typedef struct {
    int               n;
    logic [159:0]     s;
    logic [7:0]       cs;
    int               nw;
    logic [3:0][31:0] d;
    int               ntx;
    logic [7:0]       tx0;
    logic [7:0]       tx1;
    int               nerr;
    bit               done;
  } vec_t;

  vec_t vecs[8];
  int   nvec;

  initial begin
    vecs[0] = '{n: 11, s: {8'hA5, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56,
                           8'h34, 8'h12},
                cs: 8'h2A, nw: 2, d: {32'h0, 32'h0, 32'h12345678, 32'hDEADBEEF},
                ntx: 1, tx0: 8'h06, tx1: 8'h00, nerr: 0, done: 1'b1};
    vecs[1] = '{n: 9, s: {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44},
                cs: 8'h44, nw: 1, d: {32'h0, 32'h0, 32'h0, 32'h44332211},
                ntx: 1, tx0: 8'h06, tx1: 8'h00, nerr: 0, done: 1'b1};
    vecs[2] = '{n: 10, s: {8'hA5, 8'h05, 8'h00, 8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33,
                           8'h44},
                cs: 8'h44, nw: 1, d: {32'h0, 32'h0, 32'h0, 32'h44332211},
                ntx: 2, tx0: 8'h15, tx1: 8'h06, nerr: 1, done: 1'b1};
    vecs[3] = '{n: 3, s: {8'hA5, 8'h00, 8'h00}, cs: 8'h00, nw: 0, d: '0,
                ntx: 1, tx0: 8'h06, tx1: 8'h00, nerr: 0, done: 1'b1};
    vecs[4] = '{n: 19, s: {8'hA5, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                           8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
                           8'h10},
                cs: 8'h10, nw: 4, d: {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201},
                ntx: 1, tx0: 8'h06, tx1: 8'h00, nerr: 0, done: 1'b1};
    nvec = 5;
`ifdef UART_BOOT_CHECKSUM_EN
    vecs[5] = '{n: 7, s: {8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04}, cs: 8'h05,
                nw: 1, d: {32'h0, 32'h0, 32'h0, 32'h04030201},
                ntx: 1, tx0: 8'h15, tx1: 8'h00, nerr: 1, done: 1'b0};
    vecs[6] = '{n: 7, s: {8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04}, cs: 8'h04,
                nw: 1, d: {32'h0, 32'h0, 32'h0, 32'h04030201},
                ntx: 1, tx0: 8'h06, tx1: 8'h00, nerr: 0, done: 1'b1};
    nvec = 7;
`endif

    // Reset values while reset is held
    repeat (3) @(negedge clk);
    check("rst_cpu_rst", 32'(dut_cpu_rst), 1);
    check("rst_done", 32'(dut_done), 0);
    check("rst_error", 32'(dut_error), 0);
    check("rst_mmio_re", 32'(bus.mmio_re), 0);
    check("rst_mmio_we", 32'(bus.mmio_we), 0);
    check("rst_mmio_addr", bus.mmio_addr, 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_addr", bus.mem_addr, 0);

    // Directed table
    for (int v = 0; v < nvec; v++) begin
      do_reset();
      stim.delete();
      for (int i = 0; i < vecs[v].n; i++) stim.push_back(vecs[v].s[8*(vecs[v].n-1-i) +: 8]);
      if (CsumEn) stim.push_back(vecs[v].cs);
      load_stim();
      exp_wr.delete();
      for (int i = 0; i < vecs[v].nw; i++) exp_wr.push_back({32'(4 * i), vecs[v].d[i]});
      exp_tx.delete();
      if (vecs[v].ntx >= 1) exp_tx.push_back(vecs[v].tx0);
      if (vecs[v].ntx >= 2) exp_tx.push_back(vecs[v].tx1);
      exp_err  = vecs[v].nerr;
      exp_done = vecs[v].done;
      wait_idle(exp_tx.size());
      compare_run($sformatf("vec%0d", v));
    end

    // TX busy held at reply time
    do_reset();
    tx_busy = 1'b1;
    stim = '{8'hA5, 8'h00, 8'h00};
    if (CsumEn) stim.push_back(8'h00);
    load_stim();
    wait_drained();
    repeat (50) @(negedge clk);
    check("txbusy_no_write", tx_log.size(), 0);
    check("txbusy_cpu_rst", 32'(dut_cpu_rst), 1);
    tx_busy = 1'b0;
    exp_wr.delete();
    exp_tx = '{AckByte};
    exp_err = 0;
    exp_done = 1'b1;
    wait_idle(1);
    compare_run("txbusy");

    // Reset after two data bytes
    do_reset();
    stim = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
    load_stim();
    wait_drained();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_cpu_rst", 32'(dut_cpu_rst), 1);
    check("midrst_no_write", wr_log.size(), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    stim = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    if (CsumEn) stim.push_back(8'h44);
    load_stim();
    exp_wr = '{{32'h0, 32'h44332211}};
    exp_tx = '{AckByte};
    exp_err = 0;
    exp_done = 1'b1;
    wait_idle(1);
    compare_run("midrst");

    // Random frames against the parser model
    for (int it = 0; it < 20; it++) begin
      int n;
      logic [7:0] b;
      bit bad;
      do_reset();
      stim.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == MagicByte) b = 8'h00;
        stim.push_back(b);
      end
      n = $urandom_range(0, MaxW + 2);
      if ($urandom_range(0, 7) == 0) n = 256 + $urandom_range(0, 3);
      bad = CsumEn && ($urandom_range(0, 3) == 0);
      add_frame(n, bad);
      if (n > MaxW || bad) add_frame($urandom_range(0, MaxW), 1'b0);
      load_stim();
      model();
      wait_idle(exp_tx.size());
      compare_run($sformatf("rnd%0d", it));
    end

    check("protocol_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Hardware boot loader that acts as the MMIO initiator for the UART peripheral's register window (RX data at BASE_ADDR, TX data at +4, status at +8). It holds the CPU in reset and polls the UART for a framed program image. It writes the image word-by-word into instruction memory, then replies to the host with an ACK/NAK byte through the TX register. It sits between the UART peripheral and the instruction-memory write port. It is active only from reset until load completion.

## Interface
- CLK_BASE: `BASE_ADDR`, default 32'h1000_0000; UART register window base.
- `LOAD_ADDR`, default 32'h0000_0000; memory byte address of the first image word.
- `MAX_WORDS`, default 4096; largest accepted image length in words.
- i_clk  in  1  sole clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- o_mmio_addr  out  32  UART register address.
- o_mmio_data_out  out  8  byte written to TX register.
- i_mmio_data_in  in  8  combinational read data from UART, valid in the same cycle as o_mmio_re.
- o_mmio_we  out  1  write strobe, one cycle.
- o_mmio_re  out  1  read strobe, one cycle. A read of RX data pops the byte.
- o_mem_addr  out  32  word-aligned byte address.
- o_mem_wdata  out  32  little-endian assembled word.
- o_mem_we  out  1  one-cycle write pulse.
- o_cpu_rst  out  1  held high until load succeeds.
- o_done  out  1  sticky, high after a successful load.
- o_error  out  1  one-cycle pulse on a framing or length error.

## Operation
- Frame from host:
  - magic byte 8'hA5
  - 16-bit word count N, little-endian
  - N×4 data bytes, little-endian per word
  - checksum byte if enabled
- Frame phases are MAGIC, LEN_LO, LEN_HI, DATA, CSUM.
- FSM states:
  - POLL_RX: read STATUS. If bit0=1, go to READ_RX. Otherwise stay.
  - READ_RX: read RX_DATA and capture the byte. Go to PROCESS.
  - PROCESS: act on the byte according to the current phase.
  - POLL_TX: read STATUS. If bit1=0, go to WRITE_TX.
  - WRITE_TX: write the reply byte to TX. Then go to DONE on ACK, or to POLL_RX in phase MAGIC on NAK.
  - DONE: terminal state; exit only by reset.
- MAGIC phase: any byte other than A5 is discarded silently and the FSM stays in MAGIC.
- LEN_HI phase:
  - N > MAX_WORDS: pulse o_error and send NAK 8'h15.
  - N = 0: skip DATA and go straight to CSUM (or send ACK if the checksum is compiled out).
- DATA phase:
  - A byte counter (2 bits) shifts each byte into [8k+7:8k] of the word.
  - On the 4th byte, PROCESS pulses o_mem_we with o_mem_addr = LOAD_ADDR + 4·idx, then increments idx.
  - After word N, DATA exits.
- Success path: ACK 8'h06 is sent. In the WRITE_TX cycle, o_done goes to 1 and o_cpu_rst goes to 0.
- At most one MMIO strobe is active per cycle, and never we and re together.
- o_mmio_addr is driven only while a strobe is active; otherwise it is 0.

## Timing
- Reset values:
  - o_cpu_rst = 1
  - all other outputs = 0
  - state POLL_RX, phase MAGIC, idx = 0, byte counter = 0
- Minimum cost per byte is 3 cycles: POLL_RX (ready seen), then READ_RX, then PROCESS.
- o_mem_we is asserted in the PROCESS cycle of the last byte of the word, i.e. 2 cycles after that byte's status poll.
- An ACK/NAK reply needs at least 2 cycles (POLL_TX, then WRITE_TX) after PROCESS.
- Assertion of i_rst mid-load aborts on the next edge:
  - partial words are dropped
  - o_cpu_rst returns to 1
  - memory already written is not rolled back
- The idx address arithmetic is 32-bit and wraps modulo 2^32. Wrap is unreachable with the default MAX_WORDS.

## Configuration
- `UART_BOOT_CHECKSUM_EN` defined:
  - An 8-bit XOR accumulator covers all data bytes (not magic or length); it is cleared on entry to MAGIC.
  - The CSUM byte is compared against the accumulator: match sends ACK and completes; mismatch pulses o_error, sends NAK, and returns to MAGIC.
  - Memory writes still occur before the check.
- Undefined: the CSUM phase is absent and ACK is sent right after the last word.

## Structure
- Package uart_boot_pkg holds:
  - state and phase enums
  - MAGIC = 8'hA5, ACK = 8'h06, NAK = 8'h15
  - register offsets RX = 0, TX = 4, STATUS = 8
- Single module; no sub-module is warranted. Word packing and checksum are small enough to stay inline.

## Test plan
- Normal load: send A5 02 00 EF BE AD DE 78 56 34 12 with a UART model that raises rx_valid per byte.
  - Expect mem writes 0xDEADBEEF at 0x0 and 0x12345678 at 0x4.
  - Expect TX of 06, o_done = 1, o_cpu_rst = 0.
- Garbage before magic: send 00 FF A5 01 00 11 22 33 44.
  - Expect the leading bytes ignored, one write 0x44332211 at 0x0, then ACK.
- Length over limit: with MAX_WORDS = 4, send A5 05 00.
  - Expect an o_error pulse, TX 15, no mem writes, then a following valid frame accepted.
- Zero length: send A5 00 00 (plus checksum 00 if enabled).
  - Expect ACK with no writes and o_done = 1.
- TX busy: hold status bit1 = 1 for 50 cycles at ACK time.
  - Expect no o_mmio_we until bit1 clears, then exactly one write of 06 to BASE_ADDR+4.
- Checksum (macro on): send A5 01 00 01 02 03 04 with CSUM 04 → ACK. The same frame with CSUM 05 → o_error, NAK, o_cpu_rst stays 1.
- Reset mid-DATA: assert i_rst after 2 data bytes.
  - Expect o_cpu_rst = 1, no partial write, and the next frame written starting at LOAD_ADDR.
